// File: rtl/fix_pkg.sv
// rtl/fix_pkg.sv - shared constants and types for the FIX checksum controller
package fix_pkg;

    localparam logic [7:0] SOH     = 8'h01;
    localparam logic [7:0] CH_8    = 8'h38;
    localparam logic [7:0] CH_1    = 8'h31;
    localparam logic [7:0] CH_0    = 8'h30;
    localparam logic [7:0] CH_EQ   = 8'h3D;
    localparam logic [7:0] CH_DIG0 = 8'h30;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BODY   = 3'd1,
        DIG    = 3'd2,
        TERM   = 3'd3,
        RESULT = 3'd4
    } cs_state_e;

    typedef enum logic [1:0] {
        OK        = 2'd0,
        MISMATCH  = 2'd1,
        BAD_DIGIT = 2'd2,
        OVERFLOW  = 2'd3
    } cs_err_e;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= CH_DIG0) && (b <= 8'h39);
    endfunction

endpackage

// File: rtl/fix_cs_accum.sv
// rtl/fix_cs_accum.sv - wrapping byte-sum accumulator with SOH snapshot
module fix_cs_accum
    import fix_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear_i,
    input  logic       load_i,
    input  logic       add_i,
    input  logic [7:0] data_i,
    output logic [7:0] acc_o,
    output logic [7:0] snap_o
);

    logic [7:0] acc_q, acc_d;
    logic [7:0] snap_q, snap_d;
    logic [7:0] sum;

    assign sum = acc_q + data_i;

    always_comb begin
        acc_d  = acc_q;
        snap_d = snap_q;
        if (clear_i) begin
            acc_d  = 8'h00;
            snap_d = 8'h00;
        end else if (load_i) begin
            acc_d  = data_i;
            snap_d = 8'h00;
        end else if (add_i) begin
            acc_d = sum;
            // The snapshot includes the SOH itself, so the last one taken before 10= is the checksum.
            if (data_i == SOH) begin
                snap_d = sum;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= 8'h00;
            snap_q <= 8'h00;
        end else begin
            acc_q  <= acc_d;
            snap_q <= snap_d;
        end
    end

    assign acc_o  = acc_q;
    assign snap_o = snap_q;

endmodule

// File: rtl/fix_cs_ctrl.sv
// rtl/fix_cs_ctrl.sv - frames one FIX message, parses 10= trailer, issues checksum verdict
module fix_cs_ctrl
    import fix_pkg::*;
#(
    parameter int MAX_LEN = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       ready_o,
    input  logic       flush_i,
    output logic       done_o,
    output logic [1:0] err_o,
    output logic [7:0] checksum_o,
    output logic [7:0] rx_cs_o
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);

    cs_state_e   state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [9:0]  val_q, val_d;
    logic [1:0]  dcnt_q, dcnt_d;
    logic [23:0] hist_q, hist_d;
    logic        done_q, done_d;
    logic [1:0]  err_q, err_d;
    logic [7:0]  checksum_q, checksum_d;
    logic [7:0]  rx_cs_q, rx_cs_d;

    logic        acc_clear, acc_load, acc_add;
    logic [7:0]  acc, snap;
    logic        accept, len_full;
    logic [7:0]  digit;
    logic [9:0]  val_next;

    fix_cs_accum u_accum (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (acc_clear),
        .load_i  (acc_load),
        .add_i   (acc_add),
        .data_i  (data_i),
        .acc_o   (acc),
        .snap_o  (snap)
    );

    assign ready_o  = (state_q != RESULT);
    assign accept   = valid_i & ready_o & ~flush_i;
    assign len_full = (len_q == LEN_W'(MAX_LEN));
    assign digit    = data_i - CH_DIG0;
    assign val_next = (val_q << 3) + (val_q << 1) + {2'b00, digit};

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        val_d      = val_q;
        dcnt_d     = dcnt_q;
        hist_d     = hist_q;
        done_d     = 1'b0;
        err_d      = err_q;
        checksum_d = checksum_q;
        rx_cs_d    = rx_cs_q;
        acc_clear  = 1'b0;
        acc_load   = 1'b0;
        acc_add    = 1'b0;

        if (flush_i) begin
            state_d   = IDLE;
            len_d     = '0;
            val_d     = '0;
            dcnt_d    = '0;
            hist_d    = '0;
            acc_clear = 1'b1;
        end else if (state_q == RESULT) begin
            state_d = IDLE;
        end else if (accept) begin
            if (state_q == IDLE) begin
                if (data_i == CH_8) begin
                    state_d  = BODY;
                    acc_load = 1'b1;
                    len_d    = LEN_W'(1);
                    hist_d   = {16'h0000, CH_8};
                end
            end else if (len_full) begin
                // Overflowing byte is swallowed and excluded from the reported sum.
                state_d    = RESULT;
                done_d     = 1'b1;
                err_d      = OVERFLOW;
                checksum_d = acc;
                rx_cs_d    = 8'h00;
            end else begin
                len_d = len_q + LEN_W'(1);
                case (state_q)
                    BODY: begin
                        acc_add = 1'b1;
                        hist_d  = {hist_q[15:0], data_i};
                        if ({hist_q, data_i} == {SOH, CH_1, CH_0, CH_EQ}) begin
                            state_d = DIG;
                            dcnt_d  = 2'd0;
                            val_d   = '0;
                        end
                    end
                    DIG: begin
                        if (is_digit(data_i)) begin
                            val_d  = val_next;
                            dcnt_d = dcnt_q + 2'd1;
                            if (dcnt_q == 2'd2) begin
                                state_d = TERM;
                            end
                        end else begin
                            state_d    = RESULT;
                            done_d     = 1'b1;
                            err_d      = BAD_DIGIT;
                            checksum_d = snap;
                            rx_cs_d    = 8'h00;
                        end
                    end
                    TERM: begin
                        state_d    = RESULT;
                        done_d     = 1'b1;
                        checksum_d = snap;
                        rx_cs_d    = 8'h00;
                        if (data_i != SOH || val_q > 10'd255) begin
                            err_d = BAD_DIGIT;
                        end else begin
                            rx_cs_d = val_q[7:0];
                            err_d   = (val_q[7:0] != snap) ? MISMATCH : OK;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            len_q      <= '0;
            val_q      <= '0;
            dcnt_q     <= '0;
            hist_q     <= '0;
            done_q     <= 1'b0;
            err_q      <= 2'd0;
            checksum_q <= 8'h00;
            rx_cs_q    <= 8'h00;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            val_q      <= val_d;
            dcnt_q     <= dcnt_d;
            hist_q     <= hist_d;
            done_q     <= done_d;
            err_q      <= err_d;
            checksum_q <= checksum_d;
            rx_cs_q    <= rx_cs_d;
        end
    end

    assign done_o     = done_q;
    assign err_o      = err_q;
    assign checksum_o = checksum_q;
    assign rx_cs_o    = rx_cs_q;

endmodule
